// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_framer
// Purpose  : Oversampled asynchronous serial receiver. Synchronizes the
//            incoming line, validates the start bit at its centre, samples
//            data/parity/stop bits mid-bit (optional 3-sample majority vote)
//            and presents each completed word with its error flags.
// Ports    : clk        - clock, all logic on its rising edge
//            rst        - synchronous active-high reset
//            tick       - oversample enable, OVERSAMPLE pulses per bit
//            rxbit      - asynchronous serial input, idle high
//            start_det  - one-clk pulse on a validated start bit
//            data       - last received word (held between valid pulses)
//            valid      - one-clk pulse when a frame completes
//            parity_err - parity mismatch, qualified by valid
//            frame_err  - a stop bit was sampled low, qualified by valid
//            busy       - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_framer #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int MAJORITY    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxbit,
    output logic                 start_det,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] c_CNT_LAST      = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] c_CNT_HALF      = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] c_IDX_DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] c_IDX_STOP_LAST = IW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    // Two previous tick samples; together with the current synchronized
    // value they form the 3-sample voting window.
    logic [1:0]           r_hist;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic                 w_line;
    logic [2:0]           w_win;
    logic                 w_bit;
    logic                 w_par_xor;
    logic                 w_par_bad;

    assign w_line = r_sync2;
    assign w_win  = {r_hist, r_sync2};

    if (MAJORITY != 0) begin : g_majority
        assign w_bit = (w_win[0] & w_win[1]) | (w_win[0] & w_win[2]) | (w_win[1] & w_win[2]);
    end else begin : g_single
        assign w_bit = w_win[0];
    end

    // r_shift holds every data bit once the parity bit is being sampled.
    assign w_par_xor = (^r_shift) ^ w_bit;
    assign w_par_bad = (PARITY_MODE == 1) ? w_par_xor : ~w_par_xor;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_hist     <= 2'b11;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            data       <= '0;
            start_det  <= 1'b0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync1    <= rxbit;
            r_sync2    <= r_sync1;
            start_det  <= 1'b0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (tick) begin
                r_hist <= {r_hist[0], r_sync2};
                case (r_state)
                    S_IDLE: begin
                        if (!w_line) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (r_cnt == c_CNT_HALF) begin
                            r_cnt <= '0;
                            if (!w_bit) begin
                                start_det <= 1'b1;
                                r_state   <= S_DATA;
                                r_idx     <= '0;
                                r_perr    <= 1'b0;
                                r_ferr    <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_line) begin
                            // Line went high before mid-start: treat as a glitch.
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt   <= '0;
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                            if (r_idx == c_IDX_DATA_LAST) begin
                                r_idx   <= '0;
                                r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt   <= '0;
                            r_perr  <= w_par_bad;
                            r_idx   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt <= '0;
                            if (r_idx == c_IDX_STOP_LAST) begin
                                data       <= r_shift;
                                valid      <= 1'b1;
                                parity_err <= (PARITY_MODE != 0) && r_perr;
                                frame_err  <= r_ferr | ~w_bit;
                                r_idx      <= '0;
                                // A line still low here is a break or a
                                // framing error: wait for it to recover.
                                r_state    <= w_line ? S_IDLE : S_WAIT_IDLE;
                            end else begin
                                r_ferr <= r_ferr | ~w_bit;
                                r_idx  <= r_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_line) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_framer
// Purpose  : Directed bench for uart_rx_framer. One instance with default
//            parameters, one with even parity. Each sent frame registers
//            the cycle its start_det and valid must appear and the word and
//            flags they must carry; a per-cycle compare process checks both
//            instances against those expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framer;

    localparam int OVS  = 16;
    localparam int HALF = OVS / 2;

    typedef struct {
        int sel;
        int cyc;
    } sexp_t;

    typedef struct {
        int         sel;
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } vexp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;

    logic       sd0, v0, pe0, fe0, busy0;
    logic [7:0] d0;
    logic       sd1, v1, pe1, fe1, busy1;
    logic [7:0] d1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit armed = 1'b0;
    int nvalid0 = 0, nvalid1 = 0, nstart0 = 0, nstart1 = 0;
    logic last_pe1 = 1'b0;
    logic last_fe0 = 1'b0;

    sexp_t sq[$];
    vexp_t vq[$];

    uart_rx_framer dut (
        .clk(clk), .rst(rst), .tick(tick), .rxbit(rx0),
        .start_det(sd0), .data(d0), .valid(v0),
        .parity_err(pe0), .frame_err(fe0), .busy(busy0)
    );

    uart_rx_framer #(.PARITY_MODE(1)) dut_p (
        .clk(clk), .rst(rst), .tick(tick), .rxbit(rx1),
        .start_det(sd1), .data(d1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cmp_dut(input int k, input logic sd, input logic v,
                           input logic [7:0] d, input logic pe, input logic fe);
        logic s_due, v_due;
        s_due = (sq.size() > 0) && (sq[0].sel == k) && (sq[0].cyc == cyc);
        v_due = (vq.size() > 0) && (vq[0].sel == k) && (vq[0].cyc == cyc);
        checks++;
        if (sd !== s_due) begin
            failures++;
            $display("FAIL start_det dut%0d cyc=%0d got=%b want=%b", k, cyc, sd, s_due);
        end
        checks++;
        if (v !== v_due) begin
            failures++;
            $display("FAIL valid dut%0d cyc=%0d got=%b want=%b", k, cyc, v, v_due);
        end
        if (v_due && v === 1'b1) begin
            checks += 3;
            if (d !== vq[0].d) begin
                failures++;
                $display("FAIL data dut%0d cyc=%0d got=%0h want=%0h", k, cyc, d, vq[0].d);
            end
            if (pe !== vq[0].pe) begin
                failures++;
                $display("FAIL parity_err dut%0d cyc=%0d got=%b want=%b", k, cyc, pe, vq[0].pe);
            end
            if (fe !== vq[0].fe) begin
                failures++;
                $display("FAIL frame_err dut%0d cyc=%0d got=%b want=%b", k, cyc, fe, vq[0].fe);
            end
        end else if (!v_due) begin
            checks++;
            if ({pe, fe} !== 2'b00) begin
                failures++;
                $display("FAIL flags_without_valid dut%0d cyc=%0d got=%b%b want=00", k, cyc, pe, fe);
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp_dut(0, sd0, v0, d0, pe0, fe0);
            cmp_dut(1, sd1, v1, d1, pe1, fe1);
            if (sq.size() > 0 && sq[0].cyc <= cyc) void'(sq.pop_front());
            if (vq.size() > 0 && vq[0].cyc <= cyc) void'(vq.pop_front());
            if (v0 === 1'b1) begin nvalid0++; last_fe0 = fe0; end
            if (v1 === 1'b1) begin nvalid1++; last_pe1 = pe1; end
            if (sd0 === 1'b1) nstart0++;
            if (sd1 === 1'b1) nstart1++;
        end
    end

    task automatic drive(input int k, input logic lv);
        if (k == 0) rx0 = lv;
        else        rx1 = lv;
    endtask

    task automatic idle(input int k, input logic lv, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            drive(k, lv);
        end
    endtask

    // Sends one frame on line k. The start edge is seen by the receiver
    // three edges after it is driven (two synchronizer flops plus the
    // detecting tick); start is confirmed HALF ticks later and every
    // following bit is sampled OVS ticks after the previous one.
    // rst_bit >= 0 pulses rst during that data bit and expects no valid.
    task automatic send_frame(input int k, input logic [7:0] d, input int pmode,
                              input logic pbit, input logic stop_v,
                              input bit spike, input int rst_bit);
        logic b[11];
        int   n;
        int   s;
        logic lv;
        logic pe;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = d[i];
        n = 9;
        if (pmode != 0) begin
            b[n] = pbit;
            n++;
        end
        b[n] = stop_v;
        n++;
        pe = 1'b0;
        if (pmode == 1) pe = (^d) ^ pbit;
        if (pmode == 2) pe = ~((^d) ^ pbit);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < OVS; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) begin
                    s = cyc;
                    sq.push_back('{k, s + 3 + HALF});
                    if (rst_bit < 0)
                        vq.push_back('{k, s + 3 + HALF + OVS * (n - 1), d, pe, ~stop_v});
                end
                lv = b[i];
                if (spike && i >= 1 && i <= 8 && c == HALF) lv = 1'b0;
                if (rst_bit >= 0 && i == 1 + rst_bit && c == 4) rst = 1'b1;
                if (rst_bit >= 0 && i == 1 + rst_bit && c == 6) rst = 1'b0;
                drive(k, lv);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data",       {24'd0, d0}, 32'h0);
        check("rst_valid",      {31'd0, v0}, 32'h0);
        check("rst_start_det",  {31'd0, sd0}, 32'h0);
        check("rst_busy",       {31'd0, busy0}, 32'h0);
        check("rst_flags",      {30'd0, pe0, fe0}, 32'h0);
        check("rst_busy_p",     {31'd0, busy1}, 32'h0);
        rst = 1'b0;
        armed = 1'b1;
        idle(0, 1'b1, 2 * OVS);

        // 0x5A, 8N1
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 1'b0, -1);
        idle(0, 1'b1, 2 * OVS);
        check("5a_data", {24'd0, d0}, 32'h5A);
        check("5a_busy", {31'd0, busy0}, 32'h0);

        // 5-tick low glitch on an idle line
        idle(0, 1'b0, 5);
        idle(0, 1'b1, 3);
        check("glitch_busy_early", {31'd0, busy0}, 32'h1);
        idle(0, 1'b1, 2 * OVS);
        check("glitch_busy", {31'd0, busy0}, 32'h0);
        check("glitch_data_hold", {24'd0, d0}, 32'h5A);

        // even parity: 0x07 has three ones
        send_frame(1, 8'h07, 1, 1'b0, 1'b1, 1'b0, -1);
        idle(1, 1'b1, 2 * OVS);
        check("par0_data", {24'd0, d1}, 32'h07);
        check("par0_perr", {31'd0, last_pe1}, 32'h1);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1'b0, -1);
        idle(1, 1'b1, 2 * OVS);
        check("par1_perr", {31'd0, last_pe1}, 32'h0);

        // stop bit low, then break for 40 bit times
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 1'b0, -1);
        idle(0, 1'b0, 40 * OVS);
        check("break_ferr", {31'd0, last_fe0}, 32'h1);
        check("break_data", {24'd0, d0}, 32'h3C);
        check("break_busy", {31'd0, busy0}, 32'h1);
        idle(0, 1'b1, 2 * OVS);
        check("break_recover_busy", {31'd0, busy0}, 32'h0);
        send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 1'b0, -1);
        idle(0, 1'b1, 2 * OVS);
        check("c3_data", {24'd0, d0}, 32'hC3);
        check("c3_ferr", {31'd0, last_fe0}, 32'h0);

        // one-tick low spike on each data bit's mid-sample
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 1'b1, -1);
        idle(0, 1'b1, 2 * OVS);
        check("spike_data", {24'd0, d0}, 32'hFF);

        // reset during data bit 4 (bits 4..7 and stop are high)
        send_frame(0, 8'hF5, 0, 1'b0, 1'b1, 1'b0, 4);
        idle(0, 1'b1, 2 * OVS);
        check("rst_mid_busy", {31'd0, busy0}, 32'h0);
        check("rst_mid_data", {24'd0, d0}, 32'h0);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, 1'b0, -1);
        idle(0, 1'b1, 2 * OVS);
        check("81_data", {24'd0, d0}, 32'h81);

        check("count_valid0", nvalid0, 32'd5);
        check("count_valid1", nvalid1, 32'd2);
        check("count_start0", nstart0, 32'd6);
        check("count_start1", nstart1, 32'd2);
        check("pending_start", sq.size(), 32'd0);
        check("pending_valid", vq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
